// File: rtl/gameboy_pkg.sv
// Shared definitions for the gameboy system: serial port addresses, FSM states and IRQ bit index.
package gameboy_pkg;

  localparam logic [15:0] SERIAL_SB_ADDR = 16'hFF01;
  localparam logic [15:0] SERIAL_SC_ADDR = 16'hFF02;
  localparam int          IRQ_SERIAL_BIT = 3;

  // Low address bits seen by the serial port once the top has decoded FF01-FF02.
  localparam logic [1:0] SER_ADDR_SB = 2'b01;
  localparam logic [1:0] SER_ADDR_SC = 2'b10;

  typedef enum logic [1:0] {
    SER_IDLE     = 2'd0,
    SER_INT_LOW  = 2'd1,
    SER_INT_HIGH = 2'd2,
    SER_EXT      = 2'd3
  } serial_state_t;

  function automatic logic [7:0] sc_read_value(input logic start, input logic clk_sel);
    return {start, 6'b111111, clk_sel};
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous pin plus a previous-value register for edge detection.
module sync_edge_detect #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
      r_prev <= RESET_VAL;
    end else begin
      r_meta <= async_in;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign level = r_sync;
  assign rise  = r_sync & ~r_prev;
  assign fall  = ~r_sync & r_prev;

endmodule

// File: rtl/serial_port.sv
// serial_port: link-cable SB/SC registers, internal/external clocked shift engine, IRQ on completion.
// Define SERIAL_STDOUT_EN to echo SB to the simulator console when an internal transfer starts.
//
//   state    | meaning
//   IDLE     | no transfer; SB and SC writable
//   INT_LOW  | internal clock, link clock low, data driven on entry
//   INT_HIGH | internal clock, link clock high, shift on entry
//   EXT      | external clock, act on synchronized link clock edges
module serial_port
  import gameboy_pkg::*;
#(
  parameter int CLK_DIV = 512
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] ctrl_addr,
  input  logic       ctrl_enable,
  input  logic       ctrl_write,
  input  logic [7:0] ctrl_data_in,
  output logic [7:0] ctrl_data_out,
  output logic       serial_clk_out,
  input  logic       serial_clk_in,
  output logic       serial_data_out,
  input  logic       serial_data_in,
  output logic       irq_serial
);

  localparam int                 HALF     = CLK_DIV / 2;
  localparam int                 DIV_W    = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [DIV_W-1:0]   DIV_LOAD = DIV_W'(HALF - 1);

  serial_state_t    r_state, w_state_nxt;
  logic [7:0]       r_sb, w_sb_nxt;
  logic             r_start, w_start_nxt;
  logic             r_clk_sel, w_clk_sel_nxt;
  logic [2:0]       r_cnt, w_cnt_nxt;
  logic [DIV_W-1:0] r_div, w_div_nxt;
  logic             r_sclk, w_sclk_nxt;
  logic             r_sdo, w_sdo_nxt;
  logic             r_irq, w_irq_nxt;
  logic [7:0]       r_rdata, w_rdata;
  logic             r_din_meta, r_din_sync;

  logic w_wr_sb, w_wr_sc, w_shift;
  logic w_clk_level, w_clk_rise, w_clk_fall;

  sync_edge_detect #(.RESET_VAL(1'b1)) u_clk_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (serial_clk_in),
    .level    (w_clk_level),
    .rise     (w_clk_rise),
    .fall     (w_clk_fall)
  );

  assign w_wr_sb = ctrl_enable && ctrl_write && (ctrl_addr == SER_ADDR_SB);
  assign w_wr_sc = ctrl_enable && ctrl_write && (ctrl_addr == SER_ADDR_SC);

  always_comb begin
    w_state_nxt   = r_state;
    w_sb_nxt      = r_sb;
    w_start_nxt   = r_start;
    w_clk_sel_nxt = r_clk_sel;
    w_cnt_nxt     = r_cnt;
    w_div_nxt     = r_div;
    w_sclk_nxt    = 1'b1;
    w_sdo_nxt     = r_sdo;
    w_irq_nxt     = 1'b0;
    w_shift       = 1'b0;

    case (r_state)
      SER_IDLE: begin
        if (w_wr_sb) w_sb_nxt = ctrl_data_in;
        if (w_wr_sc) begin
          w_clk_sel_nxt = ctrl_data_in[0];
          if (ctrl_data_in[7]) begin
            w_start_nxt = 1'b1;
            w_cnt_nxt   = '0;
            w_div_nxt   = DIV_LOAD;
            w_state_nxt = ctrl_data_in[0] ? SER_INT_LOW : SER_EXT;
          end
        end
      end
      SER_INT_LOW: begin
        w_sclk_nxt = 1'b0;
        if (r_div == DIV_LOAD) w_sdo_nxt = r_sb[7];
        if (r_div == '0) begin
          w_state_nxt = SER_INT_HIGH;
          w_div_nxt   = DIV_LOAD;
        end else begin
          w_div_nxt = r_div - DIV_W'(1);
        end
      end
      SER_INT_HIGH: begin
        w_shift = (r_div == DIV_LOAD);
        if (r_div == '0) begin
          w_state_nxt = SER_INT_LOW;
          w_div_nxt   = DIV_LOAD;
        end else begin
          w_div_nxt = r_div - DIV_W'(1);
        end
      end
      SER_EXT: begin
        if (w_clk_fall) w_sdo_nxt = r_sb[7];
        w_shift = w_clk_rise;
      end
      default: w_state_nxt = SER_IDLE;
    endcase

    // Shift/completion wins over a coincident bus write; the write is then treated as a busy write.
    // Input is always taken from the synchronized pin so it never feeds SB metastable.
    if (w_shift) begin
      w_sb_nxt  = {r_sb[6:0], r_din_sync};
      w_cnt_nxt = r_cnt + 3'd1;
      if (r_cnt == 3'd7) begin
        w_irq_nxt   = 1'b1;
        w_start_nxt = 1'b0;
        w_cnt_nxt   = '0;
        w_state_nxt = SER_IDLE;
      end
    end

    if ((r_state != SER_IDLE) && w_wr_sc && !ctrl_data_in[7]) begin
      w_clk_sel_nxt = ctrl_data_in[0];
      w_start_nxt   = 1'b0;
      w_cnt_nxt     = '0;
      w_div_nxt     = '0;
      w_sclk_nxt    = 1'b1;
      w_state_nxt   = SER_IDLE;
    end
  end

  always_comb begin
    w_rdata = 8'hFF;
    case (ctrl_addr)
      SER_ADDR_SB: w_rdata = r_sb;
      SER_ADDR_SC: w_rdata = sc_read_value(r_start, r_clk_sel);
      default:     w_rdata = 8'hFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= SER_IDLE;
      r_sb       <= '0;
      r_start    <= 1'b0;
      r_clk_sel  <= 1'b0;
      r_cnt      <= '0;
      r_div      <= '0;
      r_sclk     <= 1'b1;
      r_sdo      <= 1'b1;
      r_irq      <= 1'b0;
      r_rdata    <= '0;
      r_din_meta <= 1'b1;
      r_din_sync <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_sb       <= w_sb_nxt;
      r_start    <= w_start_nxt;
      r_clk_sel  <= w_clk_sel_nxt;
      r_cnt      <= w_cnt_nxt;
      r_div      <= w_div_nxt;
      r_sclk     <= w_sclk_nxt;
      r_sdo      <= w_sdo_nxt;
      r_irq      <= w_irq_nxt;
      r_din_meta <= serial_data_in;
      r_din_sync <= r_din_meta;
      if (ctrl_enable && !ctrl_write) r_rdata <= w_rdata;
    end
  end

`ifdef SERIAL_STDOUT_EN
  always @(posedge clk) begin
    if (reset_n && (r_state == SER_IDLE) && w_wr_sc && ctrl_data_in[7] && ctrl_data_in[0])
      $write("%s", r_sb);
  end
`else
  // Console echo compiled out; hardware is identical either way.
`endif

  assign ctrl_data_out   = r_rdata;
  assign serial_clk_out  = r_sclk;
  assign serial_data_out = r_sdo;
  assign irq_serial      = r_irq;

endmodule

// File: tb/tb_serial_port.sv
// Directed bench for serial_port: reset, internal/external transfers, abort, busy writes, decode.
`timescale 1ns/1ps
module tb_serial_port;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] ctrl_addr = 2'b00;
  logic       ctrl_enable = 1'b0;
  logic       ctrl_write = 1'b0;
  logic [7:0] ctrl_data_in = 8'h00;
  logic [7:0] ctrl_data_out;
  logic       serial_clk_out;
  logic       serial_clk_in = 1'b1;
  logic       serial_data_out;
  logic       serial_data_in = 1'b1;
  logic       irq_serial;

  int checks = 0;
  int failures = 0;

  serial_port #(.CLK_DIV(512)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .ctrl_addr       (ctrl_addr),
    .ctrl_enable     (ctrl_enable),
    .ctrl_write      (ctrl_write),
    .ctrl_data_in    (ctrl_data_in),
    .ctrl_data_out   (ctrl_data_out),
    .serial_clk_out  (serial_clk_out),
    .serial_clk_in   (serial_clk_in),
    .serial_data_out (serial_data_out),
    .serial_data_in  (serial_data_in),
    .irq_serial      (irq_serial)
  );

  always #125 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         t0 = 0;
  bit         mon_en = 1'b0;
  int         falls = 0, bad_falls = 0, bad_rises = 0;
  int         irq_total = 0, irq_rel = -1;
  logic [7:0] mon_bits = 8'h00;
  logic       prev_sclk = 1'b1;

  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_sclk && !serial_clk_out) begin
        if ((cyc - t0 - 1) % 512 != 0) bad_falls++;
        falls++;
        mon_bits = {mon_bits[6:0], serial_data_out};
      end
      if (!prev_sclk && serial_clk_out) begin
        if ((cyc - t0 - 257) % 512 != 0) bad_rises++;
      end
    end
    if (irq_serial) begin
      irq_total++;
      irq_rel = cyc - t0;
    end
    prev_sclk = serial_clk_out;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    ctrl_addr = a; ctrl_data_in = d; ctrl_write = 1'b1; ctrl_enable = 1'b1;
    @(posedge clk); #1;
    ctrl_enable = 1'b0; ctrl_write = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    ctrl_addr = a; ctrl_write = 1'b0; ctrl_enable = 1'b1;
    @(posedge clk); #1;
    ctrl_enable = 1'b0;
    d = ctrl_data_out;
  endtask

  task automatic wait_rel(input int r);
    while (cyc - t0 < r) @(negedge clk);
  endtask

  task automatic mon_clear();
    falls = 0; bad_falls = 0; bad_rises = 0; irq_rel = -1; mon_bits = 8'h00;
  endtask

  task automatic start_internal(input logic [7:0] sb);
    bus_write(2'b01, sb);
    mon_clear();
    bus_write(2'b10, 8'h81);
    t0 = cyc;
    mon_en = 1'b1;
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;
    logic [7:0] pat;
    logic [7:0] out_bits;
    int         irq_base;
    int         pre8;

    repeat (3) @(negedge clk);
    check_eq("rst_rdata", ctrl_data_out, 8'h00);
    check_eq("rst_sclk", serial_clk_out, 1'b1);
    check_eq("rst_sdo", serial_data_out, 1'b1);
    check_eq("rst_irq", irq_serial, 1'b0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // Internal transfer, SB=A5, input held high
    serial_data_in = 1'b1;
    start_internal(8'hA5);
    wait_rel(3000);
    bus_read(2'b10, rd);
    check_eq("int_sc_busy", rd, 8'hFF);
    wait_rel(3900);
    mon_en = 1'b0;
    check_eq("int_falls", falls, 8);
    check_eq("int_fall_pos", bad_falls, 0);
    check_eq("int_rise_pos", bad_rises, 0);
    check_eq("int_out_bits", mon_bits, 8'hA5);
    check_eq("int_irq_cnt", irq_total, 1);
    check_eq("int_irq_cycle", irq_rel, 3841);
    bus_read(2'b01, rd);
    check_eq("int_sb_final", rd, 8'hFF);
    bus_read(2'b10, rd);
    check_eq("int_sc_final", rd, 8'h7F);

    // Busy writes: SB write ignored, SC=0x81 write leaves timing alone
    irq_base = irq_total;
    start_internal(8'h00);
    wait_rel(100);
    bus_write(2'b01, 8'h55);
    wait_rel(200);
    bus_read(2'b01, rd);
    check_eq("busy_sb_ignored", rd, 8'h00);
    wait_rel(600);
    bus_write(2'b10, 8'h81);
    wait_rel(1400);
    bus_read(2'b01, rd);
    check_eq("busy_sb_partial", rd, 8'h07);
    wait_rel(3900);
    mon_en = 1'b0;
    check_eq("busy_falls", falls, 8);
    check_eq("busy_fall_pos", bad_falls, 0);
    check_eq("busy_out_bits", mon_bits, 8'h00);
    check_eq("busy_irq_cnt", irq_total - irq_base, 1);
    check_eq("busy_irq_cycle", irq_rel, 3841);
    bus_read(2'b01, rd);
    check_eq("busy_sb_final", rd, 8'hFF);

    // Abort after three internal bits
    irq_base = irq_total;
    start_internal(8'h00);
    wait_rel(1400);
    bus_write(2'b10, 8'h00);
    wait_rel(5400);
    mon_en = 1'b0;
    check_eq("abort_irq", irq_total - irq_base, 0);
    check_eq("abort_sclk", serial_clk_out, 1'b1);
    bus_read(2'b10, rd);
    check_eq("abort_sc", rd, 8'h7E);
    bus_read(2'b01, rd);
    check_eq("abort_sb", rd, 8'h07);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); serial_clk_in = 1'b0; serial_data_in = 1'b0;
      repeat (20) @(negedge clk);
      serial_clk_in = 1'b1;
      repeat (20) @(negedge clk);
    end
    serial_data_in = 1'b1;
    bus_read(2'b01, rd);
    check_eq("abort_ext_ignored_sb", rd, 8'h07);
    check_eq("abort_ext_ignored_irq", irq_total - irq_base, 0);

    // Reset in the middle of an internal transfer
    irq_base = irq_total;
    start_internal(8'h33);
    wait_rel(700);
    mon_en = 1'b0;
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk);
    check_eq("midrst_sclk", serial_clk_out, 1'b1);
    check_eq("midrst_irq", irq_serial, 1'b0);
    check_eq("midrst_sdo", serial_data_out, 1'b1);
    check_eq("midrst_rdata", ctrl_data_out, 8'h00);
    reset_n = 1'b1;
    bus_read(2'b10, rd);
    check_eq("midrst_sc", rd, 8'h7E);
    bus_read(2'b01, rd);
    check_eq("midrst_sb", rd, 8'h00);
    repeat (600) @(negedge clk);
    check_eq("midrst_no_irq", irq_total - irq_base, 0);
    check_eq("midrst_sclk_idle", serial_clk_out, 1'b1);

    // External transfer: SB=3C out, 5A in, 40 clk per link bit
    irq_base = irq_total;
    pat = 8'h5A;
    out_bits = 8'h00;
    pre8 = -1;
    bus_write(2'b01, 8'h3C);
    bus_write(2'b10, 8'h80);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); serial_clk_in = 1'b0; serial_data_in = pat[7-i];
      repeat (20) @(negedge clk);
      out_bits = {out_bits[6:0], serial_data_out};
      if (i == 7) pre8 = irq_total - irq_base;
      serial_clk_in = 1'b1;
      repeat (20) @(negedge clk);
    end
    check_eq("ext_out_bits", out_bits, 8'h3C);
    check_eq("ext_irq_before_8th", pre8, 0);
    check_eq("ext_irq_cnt", irq_total - irq_base, 1);
    bus_read(2'b01, rd);
    check_eq("ext_sb", rd, 8'h5A);
    bus_read(2'b10, rd);
    check_eq("ext_sc", rd, 8'h7E);

    // Unmapped addresses
    bus_read(2'b00, rd);
    check_eq("dec_rd_00", rd, 8'hFF);
    bus_read(2'b11, rd);
    check_eq("dec_rd_11", rd, 8'hFF);
    bus_write(2'b11, 8'h81);
    bus_write(2'b00, 8'h12);
    repeat (10) @(negedge clk);
    check_eq("dec_sclk", serial_clk_out, 1'b1);
    bus_read(2'b01, rd);
    check_eq("dec_sb", rd, 8'h5A);
    bus_read(2'b10, rd);
    check_eq("dec_sc", rd, 8'h7E);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_port.md
# serial_port

Game Boy link-cable serial controller: the bus-responder end of the CPU's 0xFF01 (SB) / 0xFF02 (SC) accesses and the shift-register transmitter/receiver on the link pins. It sits beside the PPU and HRAM on the system bus in `gameboy` and replaces the simulation-only serial print hack. It also raises the serial interrupt request on transfer completion.

## Interface
- `CLK_DIV`, default 512: `clk` cycles per bit for an internally clocked transfer (4 MHz / 512 = 8192 Hz). Must be even and ≥ 4.
- `clk` in 1: system clock (4 MHz).
- `reset_n` in 1: synchronous, active-low reset.
- `ctrl_addr` in 2: `cpu_mem_addr[1:0]`.
  - 2'b01 = SB.
  - 2'b10 = SC.
  - Other values read 0xFF; writes to them are ignored.
- `ctrl_enable` in 1: access strobe. The top decodes 0xFF01–0xFF02.
- `ctrl_write` in 1: 1 = write, 0 = read.
- `ctrl_data_in` in 8: write data.
- `ctrl_data_out` out 8: registered read data.
- `serial_clk_out` out 1: link clock driven while in internal-clock mode. Idles high.
- `serial_clk_in` in 1: external link clock. Asynchronous.
- `serial_data_out` out 1: link data out.
- `serial_data_in` in 1: link data in. Asynchronous.
- `irq_serial` out 1: single-cycle serial interrupt request pulse.

## Operation
- **Registers**
  - SB[7:0]: shift register.
  - `start` = SC[7], `clk_sel` = SC[0]. 1 = internal clock.
  - SC read value = {start, 6'b111111, clk_sel}.
- **Reset values**
  - SB=0x00, start=0, clk_sel=0.
  - `ctrl_data_out`=0x00, `serial_clk_out`=1, `serial_data_out`=1, `irq_serial`=0.
  - FSM=IDLE, bit counter=0, divider=0.
- **FSM states:** IDLE, INT_LOW, INT_HIGH, EXT.
- **IDLE**
  - A write to SC latches `clk_sel`.
  - If bit7=1, set `start`. Go to INT_LOW if `clk_sel`=1, otherwise to EXT.
- **INT_LOW** (CLK_DIV/2 cycles)
  - `serial_clk_out`=0.
  - On entry, drive `serial_data_out`=SB[7].
  - Go to INT_HIGH.
- **INT_HIGH** (CLK_DIV/2 cycles)
  - `serial_clk_out`=1.
  - On entry, SB <= {SB[6:0], `serial_data_in`} and the bit counter increments.
  - If the count reaches 8: pulse `irq_serial`, clear `start`, go to IDLE. Otherwise return to INT_LOW.
- **EXT**
  - On a synchronized falling edge of `serial_clk_in`: `serial_data_out`=SB[7].
  - On a rising edge: shift and count, exactly as in INT_HIGH.
  - After 8 rising edges: pulse `irq_serial`, clear `start`, go to IDLE.
  - No timeout.
- **SB writes:** accepted in IDLE only; ignored while busy.
- **SC writes while busy**
  - bit7=0 aborts: go to IDLE, counter=0, no IRQ, SB keeps its partial contents, `serial_clk_out`=1.
  - bit7=1 is ignored entirely.
- **Reads:** SB while busy returns the partially shifted value.
- **Simultaneous events:** if a bus write coincides with a shift or completion cycle, the shift/completion takes priority. The write is then handled as a busy-state write.
- **Reset mid-transfer:** all state returns to reset values in that cycle; no IRQ.

## Timing
- **Read latency:** 1 cycle. `ctrl_data_out` updates on the edge at which `ctrl_enable && !ctrl_write`; otherwise it holds.
- **Write effect:** registers update on the accepting edge.
- **Internal transfer start:** the FSM enters INT_LOW on the accepting edge, so `serial_clk_out` falls on the next edge after the write.
- **Internal transfer timing** (write accepted at cycle 0, CLK_DIV=512):
  - Falling edges at cycles 1 + 512k.
  - Rising edges and samples at cycles 257 + 512k.
  - `irq_serial` is high during cycle 3841 only.
  - SC reads start=0 from cycle 3842.
- **External path:**
  - `serial_clk_in` and `serial_data_in` pass through a 2-flop synchronizer plus an edge register.
  - An edge is acted on 3 `clk` edges after the pin transition.
  - Data is sampled from the synchronized stream, aligned with the clock.
  - External clock must stay ≤ `clk`/8.

## Configuration
- **`SERIAL_STDOUT_EN` defined:** on every SC write with bit7=1 and bit0=1 accepted in IDLE, simulation executes `$write("%s", SB)`. Lets test ROMs print without a link partner. No synthesizable logic changes.
- **Undefined:** no print statements; no other change.

## Structure
- The shared package `gameboy_pkg` holds:
  - `SERIAL_SB_ADDR`=16'hFF01 and `SERIAL_SC_ADDR`=16'hFF02, for the top-level decoder.
  - The `serial_state_t` enum.
  - The interrupt bit index constant `IRQ_SERIAL_BIT`=3.
- One sub-module: `sync_edge_detect`.
  - 2-flop synchronizer plus previous-value register.
  - Outputs `level`, `rise`, `fall`.
  - Instantiated for `serial_clk_in`. `serial_data_in` uses the same synchronizer depth.

## Test plan
- **Reset values:** assert `reset_n`=0 mid-transfer for 1 cycle → `serial_clk_out`=1, `irq_serial`=0, SC reads 0x7E, SB reads 0x00.
- **Internal transfer:** SB=0xA5, SC=0x81, `serial_data_in`=1 → `serial_data_out` bits 1,0,1,0,0,1,0,1 at the falling edges; `irq_serial` only in cycle 3841; SB=0xFF; SC=0x7F.
- **External transfer:** SB=0x3C, SC=0x80, `serial_clk_in` driven at 100 kHz, `serial_data_in` pattern 0x5A → SB=0x5A, `serial_data_out` emits 0x3C MSB-first, one IRQ after the 8th rise.
- **Abort:** write SC=0x00 after 3 internal bits → no IRQ, SC=0x7E, `serial_clk_out` high, further `serial_clk_in` edges ignored.
- **Busy writes:** SB=0x55 written during a transfer → ignored, final SB reflects shifted input only. SC=0x81 written while busy → timing unchanged.
- **Address decode:** read `ctrl_addr`=2'b00/2'b11 → 0xFF. A write there changes no state.
